// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port DataMem between the processor core (port 0, "c_") and
// the host loader (port 1, "h_"). Ownership is round-robin. An owner may make
// at most MAX_BURST consecutive transfers while the other port is waiting.
//
// A port owns the memory while its grant is high. A transfer happens in any
// cycle where the owner's req is high. The memory-side signals are driven
// combinationally from the owner's request fields. Read data returns to the
// requesting port one cycle after the transfer, as a registered one-cycle pulse.
//
// Parameters
//   AW         DataMem address width
//   DW         DataMem data width
//   MAX_BURST  consecutive transfers per ownership while the other port waits
//
// Ports
//   Clk, Reset                         clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata          core request fields
//   c_gnt/c_rvalid/c_rdata             core grant and registered read response
//   h_req/h_we/h_addr/h_wdata          host loader request fields
//   h_gnt/h_rvalid/h_rdata             host grant and registered read response
//   h_lock                             (MEMARB_LOCK_EN only) host burst lock
//   mem_addr/mem_re/mem_we/mem_wdata   DataMem controls
//   mem_rdata                          DataMem read data, combinational from mem_addr
//
// Build option
//   MEMARB_LOCK_EN  adds the h_lock input. While the host owns the memory and
//                   h_lock is high, the burst limit is ignored for the host.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   // core port
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   // host loader port
   input  logic          h_req,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
`ifdef MEMARB_LOCK_EN
   input  logic          h_lock,
`endif
   output logic          h_gnt,
   output logic          h_rvalid,
   output logic [DW-1:0] h_rdata,
   // DataMem side
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_C = 2'd1;
   localparam logic [1:0] OWN_H = 2'd2;

   // The burst counter needs at least one bit, even when MAX_BURST == 1.
   localparam int            BW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);

   logic [1:0]    state, state_nxt;
   logic [BW-1:0] bcnt, bcnt_nxt;
   logic          last_owner, last_owner_nxt;   // 0 = core, 1 = host

   logic          xfer_c, xfer_h, xfer;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic [AW-1:0] hold_addr;
   logic [DW-1:0] hold_wdata;
   logic          burst_done;
   logic          host_locked;

   // ---------------------------------------------------------------------------
   // Transfer detection and memory-side muxing
   // ---------------------------------------------------------------------------
   assign c_gnt  = (state == OWN_C);
   assign h_gnt  = (state == OWN_H);

   assign xfer_c = c_gnt & c_req;
   assign xfer_h = h_gnt & h_req;
   assign xfer   = xfer_c | xfer_h;

   assign sel_we    = xfer_h ? h_we    : c_we;
   assign sel_addr  = xfer_h ? h_addr  : c_addr;
   assign sel_wdata = xfer_h ? h_wdata : c_wdata;

   assign mem_re    = xfer & ~sel_we;
   assign mem_we    = xfer &  sel_we;
   // Between transfers the bus keeps the last transfer's address/data, so the
   // memory inputs do not toggle while nobody is using them.
   assign mem_addr  = xfer ? sel_addr  : hold_addr;
   assign mem_wdata = xfer ? sel_wdata : hold_wdata;

   assign burst_done = (bcnt == BCNT_LAST);

`ifdef MEMARB_LOCK_EN
   assign host_locked = h_gnt & h_lock;
`else
   assign host_locked = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Ownership next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal assigned in this block gets a default value first. Any
   // path that skipped an assignment would otherwise infer a latch.
   always_comb begin
      state_nxt      = state;
      bcnt_nxt       = bcnt;
      last_owner_nxt = last_owner;

      case (state)
         IDLE: begin
            // On contention, the port that did not own the memory last time wins.
            if (c_req && (!h_req || last_owner)) begin
               state_nxt      = OWN_C;
               bcnt_nxt       = '0;
               last_owner_nxt = 1'b0;
            end else if (h_req) begin
               state_nxt      = OWN_H;
               bcnt_nxt       = '0;
               last_owner_nxt = 1'b1;
            end
         end

         OWN_C: begin
            if (!c_req) begin
               if (h_req) begin
                  state_nxt      = OWN_H;
                  bcnt_nxt       = '0;
                  last_owner_nxt = 1'b1;
               end else begin
                  state_nxt      = IDLE;
               end
            end else if (burst_done && h_req) begin
               state_nxt      = OWN_H;
               bcnt_nxt       = '0;
               last_owner_nxt = 1'b1;
            end else if (!burst_done) begin
               bcnt_nxt = bcnt + 1'b1;
            end
         end

         OWN_H: begin
            if (!h_req) begin
               if (c_req) begin
                  state_nxt      = OWN_C;
                  bcnt_nxt       = '0;
                  last_owner_nxt = 1'b0;
               end else begin
                  state_nxt      = IDLE;
               end
            end else if (burst_done && c_req && !host_locked) begin
               state_nxt      = OWN_C;
               bcnt_nxt       = '0;
               last_owner_nxt = 1'b0;
            end else if (!burst_done) begin
               // Under lock the counter still saturates. When the lock drops,
               // the core is admitted at the next host transfer.
               bcnt_nxt = bcnt + 1'b1;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments. Every register then
   // samples its pre-edge value, whatever the order of the statements.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         bcnt       <= '0;
         last_owner <= 1'b1;      // core wins the first contention after reset
      end else begin
         state      <= state_nxt;
         bcnt       <= bcnt_nxt;
         last_owner <= last_owner_nxt;
      end
   end

   // Held bus values and registered read responses. A read that is in flight
   // during Reset is dropped, because the reset branch takes priority.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hold_addr  <= '0;
         hold_wdata <= '0;
         c_rvalid   <= 1'b0;
         h_rvalid   <= 1'b0;
         c_rdata    <= '0;
         h_rdata    <= '0;
      end else begin
         if (xfer) begin
            hold_addr  <= sel_addr;
            hold_wdata <= sel_wdata;
         end
         c_rvalid <= xfer_c & ~c_we;
         h_rvalid <= xfer_h & ~h_we;
         if (xfer_c && !c_we) c_rdata <= mem_rdata;
         if (xfer_h && !h_we) h_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Scoreboard bench for dmem_arbiter, with a behavioural DataMem attached.
//   driver  - presents per-port transaction queues and holds each request
//             until it is granted (random mode adds new requests and drops
//             some that were not yet granted)
//   model   - a reference arbiter with its own memory image; checks grants and
//             the memory bus every cycle and pushes the expected read data
//   monitor - pops the expected read data when a port raises rvalid
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW        = 8;
   localparam int DW        = 8;
   localparam int MAX_BURST = 4;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } txn_t;

   typedef struct packed {
      logic [31:0] stamp;
      logic [7:0]  data;
   } rd_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       Reset   = 1'b1;
   logic       preload = 1'b1;
   logic       c_req = 1'b0, c_we = 1'b0, h_req = 1'b0, h_we = 1'b0;
   logic [7:0] c_addr = '0, c_wdata = '0, h_addr = '0, h_wdata = '0;
`ifdef MEMARB_LOCK_EN
   logic       h_lock   = 1'b0;
   logic       lock_cmd = 1'b0;
`endif
   logic       c_gnt, c_rvalid, h_gnt, h_rvalid, mem_re, mem_we;
   logic [7:0] c_rdata, h_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [7:0] dmem     [256];
   logic [7:0] init_mem [256];
   logic [7:0] ref_mem  [256];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc    = '0;
   logic        rst_q  = 1'b1;
   txn_t        cq[$], hq[$];
   rd_t         rq_c[$], rq_h[$];
   bit          rand_mode = 1'b0;
   int          req_pct   = 50;
   int          drop_pct  = 5;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .Clk       (clk),
      .Reset     (Reset),
      .c_req     (c_req),
      .c_we      (c_we),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_gnt     (c_gnt),
      .c_rvalid  (c_rvalid),
      .c_rdata   (c_rdata),
      .h_req     (h_req),
      .h_we      (h_we),
      .h_addr    (h_addr),
      .h_wdata   (h_wdata),
`ifdef MEMARB_LOCK_EN
      .h_lock    (h_lock),
`endif
      .h_gnt     (h_gnt),
      .h_rvalid  (h_rvalid),
      .h_rdata   (h_rdata),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Behavioural DataMem: combinational read, write at the clock edge.
   assign mem_rdata = dmem[mem_addr];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) dmem[i] <= init_mem[i];
      end else if (mem_we) begin
         dmem[mem_addr] <= mem_wdata;
      end
   end

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= Reset;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [7:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      return mk(1'($urandom), 8'($urandom_range(0, 31)), 8'($urandom));
   endfunction

   // ---------------------------------------------------------------------------
   // Driver: inputs change 1 time unit after the rising edge
   // ---------------------------------------------------------------------------
   initial begin : driver
      logic gc, gh;
      bit   skip_c, skip_h;
      txn_t t;
      forever begin
         @(negedge clk);
         gc = c_gnt;
         gh = h_gnt;
         @(posedge clk);
         #1;
         skip_c = 1'b0;
         skip_h = 1'b0;
         if (c_req && gc) t = cq.pop_front();
         else if (c_req && rand_mode && ($urandom % 100) < drop_pct) begin
            t = cq.pop_front();
            skip_c = 1'b1;
         end
         if (h_req && gh) t = hq.pop_front();
         else if (h_req && rand_mode && ($urandom % 100) < drop_pct) begin
            t = hq.pop_front();
            skip_h = 1'b1;
         end
         if (rand_mode && !skip_c && cq.size() == 0 && ($urandom % 100) < req_pct)
            cq.push_back(rand_txn());
         if (rand_mode && !skip_h && hq.size() == 0 && ($urandom % 100) < req_pct)
            hq.push_back(rand_txn());
         if (cq.size() != 0 && !skip_c) begin
            c_req = 1'b1; c_we = cq[0].we; c_addr = cq[0].addr; c_wdata = cq[0].wdata;
         end else begin
            c_req = 1'b0; c_we = 1'($urandom); c_addr = 8'($urandom); c_wdata = 8'($urandom);
         end
         if (hq.size() != 0 && !skip_h) begin
            h_req = 1'b1; h_we = hq[0].we; h_addr = hq[0].addr; h_wdata = hq[0].wdata;
         end else begin
            h_req = 1'b0; h_we = 1'($urandom); h_addr = 8'($urandom); h_wdata = 8'($urandom);
         end
`ifdef MEMARB_LOCK_EN
         h_lock = rand_mode ? (($urandom % 4) == 0 ? ~h_lock : h_lock) : lock_cmd;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Reference model. "owner" is -1/0/1 and "streak" is an unbounded count of
   // transfers made in the current ownership.
   // ---------------------------------------------------------------------------
   initial begin : model
      int   owner, last, streak, nxt;
      bit   r0, r1, ro, rx, xc, xh, locked;
      logic [7:0] la, ld, a5;
      txn_t f;
      rd_t  e;
      for (int i = 0; i < 256; i++) begin
         init_mem[i] = 8'($urandom);
         ref_mem[i]  = init_mem[i];
      end
      a5 = 8'h10;
      init_mem[a5] = 8'h5A;
      ref_mem[a5]  = 8'h5A;
      owner = -1; last = 1; streak = 0; la = '0; ld = '0;
      forever begin
         @(negedge clk);
         #1;
         check("c_gnt", {31'b0, c_gnt}, 32'(owner == 0));
         check("h_gnt", {31'b0, h_gnt}, 32'(owner == 1));
         xc = (owner == 0) && c_req;
         xh = (owner == 1) && h_req;
         if (xc || xh) begin
            f = xc ? mk(c_we, c_addr, c_wdata) : mk(h_we, h_addr, h_wdata);
            check("mem_addr", {24'b0, mem_addr}, {24'b0, f.addr});
            check("mem_wdata", {24'b0, mem_wdata}, {24'b0, f.wdata});
            check("mem_re", {31'b0, mem_re}, {31'b0, ~f.we});
            check("mem_we", {31'b0, mem_we}, {31'b0, f.we});
            if (f.we) begin
               ref_mem[f.addr] = f.wdata;
            end else begin
               e.stamp = cyc;
               e.data  = ref_mem[f.addr];
               if (xc) rq_c.push_back(e);
               else    rq_h.push_back(e);
            end
            la = f.addr;
            ld = f.wdata;
         end else begin
            check("idle_mem_re", {31'b0, mem_re}, 32'd0);
            check("idle_mem_we", {31'b0, mem_we}, 32'd0);
            check("idle_mem_addr", {24'b0, mem_addr}, {24'b0, la});
            check("idle_mem_wdata", {24'b0, mem_wdata}, {24'b0, ld});
         end
         r0 = c_req;
         r1 = h_req;
`ifdef MEMARB_LOCK_EN
         locked = (owner == 1) && h_lock;
`else
         locked = 1'b0;
`endif
         nxt = owner;
         if (owner < 0) begin
            if (r0 && r1) nxt = 1 - last;
            else if (r0)  nxt = 0;
            else if (r1)  nxt = 1;
         end else begin
            ro = (owner == 0) ? r0 : r1;
            rx = (owner == 0) ? r1 : r0;
            if (!ro) nxt = rx ? 1 - owner : -1;
            else begin
               streak++;
               if (streak >= MAX_BURST && rx && !locked) nxt = 1 - owner;
            end
         end
         if (nxt >= 0 && nxt != owner) begin
            streak = 0;
            last   = nxt;
         end
         owner = nxt;
         if (Reset) begin
            owner = -1; last = 1; streak = 0; la = '0; ld = '0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: read responses, exactly one cycle after the transfer
   // ---------------------------------------------------------------------------
   initial begin : monitor
      logic [7:0] hold_c, hold_h;
      bit         ev;
      rd_t        e;
      hold_c = '0;
      hold_h = '0;
      forever begin
         @(negedge clk);
         if (rst_q) begin
            rq_c.delete();
            rq_h.delete();
            hold_c = '0;
            hold_h = '0;
         end
         ev = (rq_c.size() != 0) && (rq_c[0].stamp + 1 == cyc);
         check("c_rvalid", {31'b0, c_rvalid}, 32'(ev));
         if (ev) begin
            e = rq_c.pop_front();
            hold_c = e.data;
         end
         check("c_rdata", {24'b0, c_rdata}, {24'b0, hold_c});
         ev = (rq_h.size() != 0) && (rq_h[0].stamp + 1 == cyc);
         check("h_rvalid", {31'b0, h_rvalid}, 32'(ev));
         if (ev) begin
            e = rq_h.pop_front();
            hold_h = e.data;
         end
         check("h_rdata", {24'b0, h_rdata}, {24'b0, hold_h});
      end
   end

   // ---------------------------------------------------------------------------
   // Scenarios; called 1 time unit after a rising edge
   // ---------------------------------------------------------------------------
   task automatic wait_idle(input int max);
      int n = 0;
      while ((cq.size() != 0 || hq.size() != 0 || c_req || h_req) && n < max) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("wait_idle_bound", 32'(n < max), 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      @(posedge clk);
      #1;
      Reset = 1'b0;
   endtask

   initial begin : main
      int n;
      repeat (3) @(posedge clk);
      #1;
      Reset   = 1'b0;
      preload = 1'b0;

      // Core-only read of a preloaded word.
      cq.push_back(mk(1'b0, 8'h10, 8'h00));
      wait_idle(40);
      check("t1_c_rdata", {24'b0, c_rdata}, 32'h5A);

      // Host writes, then core reads the same word back.
      hq.push_back(mk(1'b1, 8'h20, 8'h33));
      wait_idle(40);
      cq.push_back(mk(1'b0, 8'h20, 8'h00));
      wait_idle(40);
      check("t2_c_rdata", {24'b0, c_rdata}, 32'h33);

      // Contention right after reset: core first, then a direct handover.
      pulse_reset();
      cq.push_back(mk(1'b0, 8'h01, 8'h00));
      cq.push_back(mk(1'b0, 8'h02, 8'h00));
      hq.push_back(mk(1'b0, 8'h03, 8'h00));
      hq.push_back(mk(1'b0, 8'h04, 8'h00));
      wait_idle(60);

      // Both ports streaming: ownership alternates every MAX_BURST transfers.
      for (int i = 0; i < 12; i++) begin
         cq.push_back(rand_txn());
         hq.push_back(rand_txn());
      end
      wait_idle(200);

      // Reset during a host read burst.
      for (int i = 0; i < 6; i++) hq.push_back(mk(1'b0, 8'(i + 8), 8'h00));
      n = 0;
      while (!h_gnt && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("h_gnt_wait_bound", 32'(n < 20), 32'd1);
      @(posedge clk);
      #1;
      cq.push_back(mk(1'b0, 8'h10, 8'h00));
      cq.push_back(mk(1'b0, 8'h11, 8'h00));
      pulse_reset();
      wait_idle(100);

`ifdef MEMARB_LOCK_EN
      // Locked host burst that is longer than MAX_BURST.
      lock_cmd = 1'b1;
      for (int i = 0; i < 12; i++) hq.push_back(rand_txn());
      for (int i = 0; i < 3; i++)  cq.push_back(rand_txn());
      repeat (11) @(posedge clk);
      #1;
      lock_cmd = 1'b0;
      wait_idle(100);
`endif

      // Random traffic with occasional resets.
      rand_mode = 1'b1;
      for (int r = 0; r < 6; r++) begin
         repeat (500) @(posedge clk);
         #1;
         pulse_reset();
      end
      rand_mode = 1'b0;
      wait_idle(100);

      check("rq_c_drained", rq_c.size(), 32'd0);
      check("rq_h_drained", rq_h.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
